// File: rtl/core_clock_req.sv
// Gated-clock request generator for the core, register file and multiplier clock gates.
// Optional sleep-cycle counter enabled by defining CORE_CLOCK_REQ_SLEEP_CNT_EN.
module core_clock_req #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int RF_HOLD     = 2,
  parameter int MUL_HOLD    = 1
) (
  input  logic        f_clk,
  input  logic        g_reset,
  input  logic        clk_gate_dis,
  input  logic        wfi_req,
  input  logic        int_pending,
  input  logic        dbg_req,
  input  logic        rf_active,
  input  logic        mul_start,
  input  logic        mul_busy,
`ifdef CORE_CLOCK_REQ_SLEEP_CNT_EN
  input  logic        sleep_cnt_clr,
  output logic [31:0] sleep_cycles,
`endif
  output logic        g_clk_req,
  output logic        g_clk_rf_req,
  output logic        g_clk_mul_req,
  output logic        core_sleeping,
  output logic        wake_done
);

  localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int RF_W    = $clog2(RF_HOLD) + 1;
  localparam int MUL_W   = $clog2(MUL_HOLD) + 1;

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [RF_W-1:0]  RF_LOAD   = RF_W'(RF_HOLD);
  localparam logic [MUL_W-1:0] MUL_LOAD  = MUL_W'(MUL_HOLD);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SLEEP,
    ST_WAKE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wake_done_q, wake_done_d;
  logic [RF_W-1:0]  rf_cnt_q, rf_cnt_d;
  logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             wake_evt;
  logic             core_on;

  assign wake_evt = int_pending | dbg_req;

  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      wake_done_q <= 1'b0;
      rf_cnt_q    <= RF_LOAD;
      mul_cnt_q   <= MUL_LOAD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wake_done_q <= wake_done_d;
      rf_cnt_q    <= rf_cnt_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

  // One shared down-counter times both the idle hysteresis and the wake-up sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wake_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wfi_req && !wake_evt) begin
          state_d = ST_DRAIN;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_DRAIN: begin
        if (wake_evt || !wfi_req) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          state_d = ST_SLEEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SLEEP: begin
        if (wake_evt) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d     = ST_RUN;
          wake_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Hold counters run in every state; their requests are masked by core_on while asleep.
  always_comb begin
    rf_cnt_d  = rf_cnt_q;
    mul_cnt_d = mul_cnt_q;
    if (rf_active) begin
      rf_cnt_d = RF_LOAD;
    end else if (rf_cnt_q != '0) begin
      rf_cnt_d = rf_cnt_q - RF_W'(1);
    end
    if (mul_start || mul_busy) begin
      mul_cnt_d = MUL_LOAD;
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - MUL_W'(1);
    end
  end

  assign core_on       = (state_q != ST_SLEEP) | clk_gate_dis;
  assign g_clk_req     = core_on;
  assign g_clk_rf_req  = clk_gate_dis | (core_on & (rf_active | (rf_cnt_q != '0)));
  assign g_clk_mul_req = clk_gate_dis |
                         (core_on & (mul_start | mul_busy | (mul_cnt_q != '0)));
  assign core_sleeping = (state_q == ST_SLEEP);
  assign wake_done     = wake_done_q;

`ifdef CORE_CLOCK_REQ_SLEEP_CNT_EN
  logic [31:0] sleep_cycles_q, sleep_cycles_d;

  always_ff @(posedge f_clk or posedge g_reset) begin
    if (g_reset) begin
      sleep_cycles_q <= '0;
    end else begin
      sleep_cycles_q <= sleep_cycles_d;
    end
  end

  // Clear wins over increment; the count saturates instead of wrapping.
  always_comb begin
    sleep_cycles_d = sleep_cycles_q;
    if (sleep_cnt_clr) begin
      sleep_cycles_d = '0;
    end else if ((state_q == ST_SLEEP) && (sleep_cycles_q != 32'hFFFF_FFFF)) begin
      sleep_cycles_d = sleep_cycles_q + 32'd1;
    end
  end

  assign sleep_cycles = sleep_cycles_q;
`endif

endmodule
